// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, single-outstanding instruction-memory
// handshake and the IF/ID pipeline register. Stall, flush and redirect control
// come from the hazard unit; responses to squashed requests are dropped.
//
// state  | meaning
// -------+-------------------------------------------------------------
// ISSUE  | drive im_req/im_addr=pc for one cycle
// WAIT   | request outstanding, response wanted
// HOLD   | response captured in hold_buf while IF/ID is stalled
// DROP   | request outstanding, response belongs to a squashed path
module fetch_unit #(
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0,
   parameter logic [31:0]       NOP_INSTR = 32'h0000_0013
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              PCWrite,
   input  logic              IFID_RegWrite,
   input  logic              InstrFlush,
   input  logic [1:0]        BranchCtrl,
   input  logic [ADDR_W-1:0] pc_branch,
   input  logic [ADDR_W-1:0] pc_jalr,
   output logic              im_req,
   output logic [ADDR_W-1:0] im_addr,
   input  logic              im_rvalid,
   input  logic [31:0]       im_rdata,
   output logic [ADDR_W-1:0] IFID_pc,
   output logic [31:0]       IFID_instr,
   output logic              IFID_valid,
   output logic              fetch_busy
);

   typedef enum logic [1:0] {
      S_ISSUE = 2'd0,
      S_WAIT  = 2'd1,
      S_HOLD  = 2'd2,
      S_DROP  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [31:0]       hold_buf_q, hold_buf_d;
   logic [ADDR_W-1:0] ifid_pc_q, ifid_pc_d;
   logic [31:0]       ifid_instr_q, ifid_instr_d;
   logic              ifid_valid_q, ifid_valid_d;
   logic [ADDR_W-1:0] pc_plus4;

   assign pc_plus4 = pc_q + ADDR_W'(4);

   // Next-state, next-PC and IF/ID load decision; flush overrides every state.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      hold_buf_d   = hold_buf_q;
      ifid_pc_d    = ifid_pc_q;
      ifid_instr_d = ifid_instr_q;
      ifid_valid_d = ifid_valid_q;

      if (InstrFlush) begin
         ifid_pc_d    = '0;
         ifid_instr_d = NOP_INSTR;
         ifid_valid_d = 1'b0;
         hold_buf_d   = '0;
         case (BranchCtrl)
            2'b01:   pc_d = pc_branch;
            2'b10:   pc_d = pc_jalr;
            default: pc_d = pc_plus4;
         endcase
         // A request still in flight must have its response swallowed.
         if ((state_q == S_WAIT || state_q == S_DROP) && !im_rvalid) begin
            state_d = S_DROP;
         end else begin
            state_d = S_ISSUE;
         end
      end else begin
         case (state_q)
            S_ISSUE: begin
               state_d = S_WAIT;
               if (IFID_RegWrite) begin
                  ifid_pc_d    = '0;
                  ifid_instr_d = NOP_INSTR;
                  ifid_valid_d = 1'b0;
               end
            end
            S_WAIT: begin
               if (im_rvalid) begin
                  if (IFID_RegWrite) begin
                     ifid_pc_d    = pc_q;
                     ifid_instr_d = im_rdata;
                     ifid_valid_d = 1'b1;
                     if (PCWrite) pc_d = pc_plus4;
                     state_d = S_ISSUE;
                  end else begin
                     hold_buf_d = im_rdata;
                     state_d    = S_HOLD;
                  end
               end else if (IFID_RegWrite) begin
                  ifid_pc_d    = '0;
                  ifid_instr_d = NOP_INSTR;
                  ifid_valid_d = 1'b0;
               end
            end
            S_HOLD: begin
               if (IFID_RegWrite) begin
                  ifid_pc_d    = pc_q;
                  ifid_instr_d = hold_buf_q;
                  ifid_valid_d = 1'b1;
                  if (PCWrite) pc_d = pc_plus4;
                  state_d = S_ISSUE;
               end
            end
            S_DROP: begin
               if (im_rvalid) state_d = S_ISSUE;
               if (IFID_RegWrite) begin
                  ifid_pc_d    = '0;
                  ifid_instr_d = NOP_INSTR;
                  ifid_valid_d = 1'b0;
               end
            end
            default: state_d = S_ISSUE;
         endcase
      end
   end

   // State, PC, response buffer and IF/ID registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_ISSUE;
         pc_q         <= RESET_PC;
         hold_buf_q   <= '0;
         ifid_pc_q    <= '0;
         ifid_instr_q <= NOP_INSTR;
         ifid_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         hold_buf_q   <= hold_buf_d;
         ifid_pc_q    <= ifid_pc_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_valid_q <= ifid_valid_d;
      end
   end

   // Request strobe and busy flag decode straight from state.
   always_comb begin
      im_req     = (state_q == S_ISSUE);
      im_addr    = pc_q;
      fetch_busy = (state_q == S_ISSUE) || (state_q == S_DROP) ||
                   ((state_q == S_WAIT) && !im_rvalid);
   end

   assign IFID_pc    = ifid_pc_q;
   assign IFID_instr = ifid_instr_q;
   assign IFID_valid = ifid_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a latency-programmable instruction memory, a
// transaction-level model of the fetch stage, directed scenarios with
// literal expectations and a long randomized run.
module tb_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk, rst;
   logic        PCWrite, IFID_RegWrite, InstrFlush;
   logic [1:0]  BranchCtrl;
   logic [31:0] pc_branch, pc_jalr;
   logic        im_req;
   logic [31:0] im_addr;
   logic        im_rvalid;
   logic [31:0] im_rdata;
   logic [31:0] IFID_pc, IFID_instr;
   logic        IFID_valid, fetch_busy;

   fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
      .clk(clk), .rst(rst),
      .PCWrite(PCWrite), .IFID_RegWrite(IFID_RegWrite), .InstrFlush(InstrFlush),
      .BranchCtrl(BranchCtrl), .pc_branch(pc_branch), .pc_jalr(pc_jalr),
      .im_req(im_req), .im_addr(im_addr), .im_rvalid(im_rvalid), .im_rdata(im_rdata),
      .IFID_pc(IFID_pc), .IFID_instr(IFID_instr), .IFID_valid(IFID_valid),
      .fetch_busy(fetch_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // model: outstanding request / stale flag / buffered instruction / IF/ID
   logic [31:0] m_pc, m_buf, m_ifid_pc, m_ifid_instr;
   logic        m_pending, m_stale, m_buf_valid, m_ifid_valid;

   // memory
   logic        mem_pending;
   int          mem_cnt;
   logic [31:0] mem_addr;
   int          lat;
   bit          rand_data;

   logic        obs_req, obs_busy, obs_valid;
   logic [31:0] obs_addr, obs_pc, obs_instr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc = 32'h0; m_buf = 32'h0; m_pending = 0; m_stale = 0; m_buf_valid = 0;
      m_ifid_pc = 32'h0; m_ifid_instr = NOP; m_ifid_valid = 0;
      mem_pending = 0; mem_cnt = 0; mem_addr = 32'h0;
   endtask

   task automatic m_bubble();
      m_ifid_pc = 32'h0; m_ifid_instr = NOP; m_ifid_valid = 0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      im_rvalid = 1'b0; im_rdata = 32'h0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   // One clock cycle, entered and left 1 time unit after the rising edge.
   task automatic run_cycle();
      logic        issuing;
      logic [31:0] plus4;
      im_rvalid = 1'b0;
      im_rdata  = $urandom;
      if (mem_pending) begin
         mem_cnt--;
         if (mem_cnt == 0) begin
            mem_pending = 0;
            im_rvalid   = 1'b1;
            im_rdata    = rand_data ? $urandom : (mem_addr ^ 32'hA5A5_0000);
         end
      end
      @(negedge clk);
      obs_req = im_req; obs_addr = im_addr; obs_busy = fetch_busy;
      obs_pc = IFID_pc; obs_instr = IFID_instr; obs_valid = IFID_valid;

      issuing = !m_pending && !m_buf_valid;
      chk("im_req", obs_req, issuing);
      chk("fetch_busy", obs_busy, issuing || (m_pending && (m_stale || !im_rvalid)));
      if (issuing) chk("im_addr", obs_addr, m_pc);
      chk("IFID_pc", obs_pc, m_ifid_pc);
      chk("IFID_instr", obs_instr, m_ifid_instr);
      chk("IFID_valid", obs_valid, m_ifid_valid);

      plus4 = m_pc + 32'd4;
      if (InstrFlush) begin
         m_bubble();
         m_buf_valid = 0;
         m_pc = (BranchCtrl == 2'b01) ? pc_branch :
                (BranchCtrl == 2'b10) ? pc_jalr : plus4;
         if (m_pending && !im_rvalid) m_stale = 1;
         else m_pending = 0;
      end else if (issuing) begin
         m_pending = 1; m_stale = 0;
         if (IFID_RegWrite) m_bubble();
      end else if (m_buf_valid) begin
         if (IFID_RegWrite) begin
            m_ifid_pc = m_pc; m_ifid_instr = m_buf; m_ifid_valid = 1;
            m_buf_valid = 0;
            if (PCWrite) m_pc = plus4;
         end
      end else if (m_stale) begin
         if (im_rvalid) m_pending = 0;
         if (IFID_RegWrite) m_bubble();
      end else if (im_rvalid) begin
         m_pending = 0;
         if (IFID_RegWrite) begin
            m_ifid_pc = m_pc; m_ifid_instr = im_rdata; m_ifid_valid = 1;
            if (PCWrite) m_pc = plus4;
         end else begin
            m_buf_valid = 1; m_buf = im_rdata;
         end
      end else if (IFID_RegWrite) begin
         m_bubble();
      end

      if (obs_req) begin
         chk("single_outstanding", {31'b0, mem_pending}, 32'h0);
         mem_pending = 1; mem_cnt = lat; mem_addr = obs_addr;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic step(input logic rw, input logic pcw, input logic fl,
                       input logic [1:0] bc, input logic [31:0] pcb, input logic [31:0] pcj);
      IFID_RegWrite = rw; PCWrite = pcw; InstrFlush = fl;
      BranchCtrl = bc; pc_branch = pcb; pc_jalr = pcj;
      run_cycle();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      IFID_RegWrite = 1; PCWrite = 1; InstrFlush = 0; BranchCtrl = 2'b00;
      pc_branch = 32'h0; pc_jalr = 32'h0;
      lat = 1; rand_data = 0;
      do_reset();

      // straight-line fetch, 1-cycle memory
      step(1, 1, 0, 2'b00, 0, 0);
      chk("t1_req0", obs_req, 1);
      chk("t1_addr0", obs_addr, 32'h0);
      step(1, 1, 0, 2'b00, 0, 0);
      step(1, 1, 0, 2'b00, 0, 0);
      chk("t1_addr4", obs_addr, 32'h4);
      chk("t1_ifid_pc0", obs_pc, 32'h0);
      chk("t1_ifid_instr0", obs_instr, 32'hA5A5_0000);
      chk("t1_ifid_valid0", obs_valid, 1);
      step(1, 1, 0, 2'b00, 0, 0);
      chk("t1_bubble_valid", obs_valid, 0);
      chk("t1_bubble_instr", obs_instr, NOP);
      step(1, 1, 0, 2'b00, 0, 0);
      chk("t1_addr8", obs_addr, 32'h8);
      chk("t1_ifid_pc4", obs_pc, 32'h4);
      chk("t1_ifid_instr4", obs_instr, 32'hA5A5_0004);

      // load-use stall with the response arriving in the first stalled cycle
      step(0, 0, 0, 2'b00, 0, 0);
      step(0, 0, 0, 2'b00, 0, 0);
      chk("t2_hold_valid", obs_valid, 0);
      step(0, 0, 0, 2'b00, 0, 0);
      chk("t2_hold_busy", obs_busy, 0);
      chk("t2_hold_noreq", obs_req, 0);
      step(1, 1, 0, 2'b00, 0, 0);
      lat = 3;
      step(1, 1, 0, 2'b00, 0, 0);
      chk("t2_ifid_pc", obs_pc, 32'h8);
      chk("t2_ifid_instr", obs_instr, 32'hA5A5_0008);
      chk("t2_ifid_valid", obs_valid, 1);
      chk("t2_next_addr", obs_addr, 32'hC);

      // branch flush while waiting on a 3-cycle response
      step(1, 1, 1, 2'b01, 32'h100, 32'h0BAD_0000);
      step(1, 1, 0, 2'b00, 0, 0);
      chk("t3_drop_busy", obs_busy, 1);
      chk("t3_drop_noreq", obs_req, 0);
      lat = 1;
      step(1, 1, 0, 2'b00, 0, 0);
      chk("t3_bubble", obs_valid, 0);
      step(1, 1, 0, 2'b00, 0, 0);
      chk("t3_target_addr", obs_addr, 32'h100);

      // jalr flush coincident with the response
      step(1, 1, 1, 2'b10, 32'h4000, 32'h2000);
      step(1, 1, 0, 2'b00, 0, 0);
      chk("t4_valid", obs_valid, 0);
      chk("t4_target_addr", obs_addr, 32'h2000);

      // PC wrap-around
      step(1, 1, 1, 2'b01, 32'hFFFF_FFFC, 32'h0);
      step(1, 1, 0, 2'b00, 0, 0);
      chk("t5_addr_top", obs_addr, 32'hFFFF_FFFC);
      step(1, 1, 0, 2'b00, 0, 0);
      step(1, 1, 0, 2'b00, 0, 0);
      chk("t5_wrap_addr", obs_addr, 32'h0);
      chk("t5_ifid_pc", obs_pc, 32'hFFFF_FFFC);
      chk("t5_ifid_instr", obs_instr, 32'h5A5A_FFFC);
      step(1, 1, 0, 2'b00, 0, 0);
      lat = 3;
      step(0, 1, 0, 2'b00, 0, 0);
      chk("t6_pre_valid", obs_valid, 1);

      // asynchronous reset in the middle of WAIT
      #2 rst = 1'b0;
      #1;
      chk("t6_rst_valid", IFID_valid, 0);
      chk("t6_rst_instr", IFID_instr, NOP);
      chk("t6_rst_pc", IFID_pc, 32'h0);
      chk("t6_rst_req", im_req, 1);
      chk("t6_rst_addr", im_addr, 32'h0);
      lat = 1;
      do_reset();
      step(1, 1, 0, 2'b00, 0, 0);
      chk("t6_first_addr", obs_addr, 32'h0);

      // randomized run
      rand_data = 1;
      for (int i = 0; i < 3000; i++) begin
         logic        fl;
         logic [31:0] pcb, pcj;
         if (i == 1500) do_reset();
         lat = $urandom_range(1, 3);
         fl  = (m_pending || m_buf_valid) && ($urandom_range(0, 9) == 0);
         pcb = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
         pcj = $urandom & 32'hFFFF_FFFE;
         step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, fl,
              2'($urandom_range(0, 3)), pcb, pcj);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
